// File: rtl/load_buffer_pkg.sv
// load_buffer_pkg: shared types for the load buffer.
//   lb_state_e  - head controller states (IDLE, REQ, WAIT_DATA, WB)
//   MEM_SIZE_*  - load size encodings carried on acu_mem_size
//   lb_entry_t  - one queued load (addr, size, sign_ext, rob_tag)
package load_buffer_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        REQ       = 2'd1,
        WAIT_DATA = 2'd2,
        WB        = 2'd3
    } lb_state_e;

    localparam logic [1:0] MEM_SIZE_BYTE = 2'd0;
    localparam logic [1:0] MEM_SIZE_HALF = 2'd1;
    localparam logic [1:0] MEM_SIZE_WORD = 2'd2;

    // Storage width of the tag field; the top's ROB_IDX_W must not exceed it.
    localparam int LB_TAG_W = 8;

    typedef struct packed {
        logic [31:0]         addr;
        logic [1:0]          size;
        logic                sign_ext;
        logic [LB_TAG_W-1:0] rob_tag;
    } lb_entry_t;

endpackage

// File: rtl/load_data_align.sv
// load_data_align: combinational lane select and sign/zero extension of a
// 32-bit memory word.
//   rdata    in  32 : raw memory word (little-endian byte lanes)
//   lane     in  2  : low address bits; byte uses [1:0], half uses [1]
//   size     in  2  : MEM_SIZE_* encoding; anything else is treated as word
//   sign_ext in  1  : 1 = sign-extend, 0 = zero-extend
//   data     out 32 : formatted result
module load_data_align
    import load_buffer_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  lane,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    output logic [31:0] data
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = rdata[{lane, 3'b000} +: 8];
        // Misaligned halves simply use lane[1]; lane[0] is ignored.
        half_v = lane[1] ? rdata[31:16] : rdata[15:0];
        data   = rdata;
        case (size)
            MEM_SIZE_BYTE: data = {{24{sign_ext & byte_v[7]}}, byte_v};
            MEM_SIZE_HALF: data = {{16{sign_ext & half_v[15]}}, half_v};
            default:       data = rdata;
        endcase
    end

endmodule

// File: rtl/load_buffer.sv
// load_buffer: circular FIFO of pending loads with a single-outstanding
// memory request controller at the head.
//   clock, reset (async, active-high)
//   acu_*                 in  : load allocation from the address-calculation unit
//   lb_exec_stall         in  : hazard unit holds off new memory requests
//   Dmem_wait, Dmem_rdata in  : memory handshake / read data (one cycle after accept)
//   branch_misprediction  in  : flush of all entries and any response in flight
//   lb_wr_written         in  : writeback consumed
//   lb_full               out : LB_DEPTH entries held
//   lb_read_mem, lb_mem_addr out : word-aligned memory read request
//   lb_wr_valid, lb_wr_data, lb_wr_rob_tag out : pending writeback
//   lb_state, lb_count    out : controller state and occupancy (debug)
//
// Handshakes: a memory request transfers on a rising edge where lb_read_mem=1
// and Dmem_wait=0; a writeback transfers on a rising edge where lb_wr_valid=1
// and lb_wr_written=1. lb_wr_valid, once high, holds until that transfer.
module load_buffer
    import load_buffer_pkg::*;
#(
    parameter int LB_DEPTH  = 4,
    parameter int ROB_IDX_W = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  acu_rd_mem,
    input  logic [31:0]           acu_addr,
    input  logic [1:0]            acu_mem_size,
    input  logic                  acu_sign_ext,
    input  logic [ROB_IDX_W-1:0]  acu_rob_tag,
    input  logic                  lb_exec_stall,
    input  logic                  Dmem_wait,
    input  logic [31:0]           Dmem_rdata,
    input  logic                  branch_misprediction,
    input  logic                  lb_wr_written,
    output logic                  lb_full,
    output logic                  lb_read_mem,
    output logic [31:0]           lb_mem_addr,
    output logic                  lb_wr_valid,
    output logic [31:0]           lb_wr_data,
    output logic [ROB_IDX_W-1:0]  lb_wr_rob_tag,
    output lb_state_e             lb_state,
    output logic [$clog2(LB_DEPTH):0] lb_count
);

    localparam int PTR_W = $clog2(LB_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    lb_state_e          state, state_next;
    logic [PTR_W-1:0]   head, tail;
    logic [CNT_W-1:0]   count;
    lb_entry_t          entries [LB_DEPTH];
    lb_entry_t          head_entry;
    logic               alloc_en;
    logic               pop;
    logic [31:0]        aligned_data;
    logic               unused_tag_bits;

    assign head_entry  = entries[head];
    assign lb_full     = (count == CNT_W'(LB_DEPTH));
    assign lb_state    = state;
    assign lb_count    = count;
    // A flush drops a same-cycle allocation; full blocks it even if a pop
    // happens on the same edge.
    assign alloc_en    = acu_rd_mem & ~lb_full & ~branch_misprediction;
    assign pop         = (state == WAIT_DATA);
    assign unused_tag_bits = ^head_entry.rob_tag;

    load_data_align u_align (
        .rdata    (Dmem_rdata),
        .lane     (head_entry.addr[1:0]),
        .size     (head_entry.size),
        .sign_ext (head_entry.sign_ext),
        .data     (aligned_data)
    );

    always_ff @(posedge clock) begin
        if (alloc_en) begin
            entries[tail] <= '{addr:     acu_addr,
                               size:     acu_mem_size,
                               sign_ext: acu_sign_ext,
                               rob_tag:  LB_TAG_W'(acu_rob_tag)};
        end
    end

    always_comb begin
        state_next  = state;
        lb_read_mem = 1'b0;
        lb_mem_addr = 32'h0;
        lb_wr_valid = 1'b0;
        case (state)
            // Leaving on the allocating edge gives the request in the very
            // next cycle, keeping load-to-writeback at three edges.
            IDLE: begin
                if (count != '0 || alloc_en) state_next = REQ;
            end
            REQ: begin
                lb_read_mem = ~lb_exec_stall;
                lb_mem_addr = {head_entry.addr[31:2], 2'b00};
                if (lb_read_mem && !Dmem_wait) state_next = WAIT_DATA;
            end
            WAIT_DATA: begin
                state_next = WB;
            end
            WB: begin
                lb_wr_valid = 1'b1;
                if (lb_wr_written) state_next = (count != '0) ? REQ : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            lb_wr_data    <= 32'h0;
            lb_wr_rob_tag <= '0;
        end else if (branch_misprediction) begin
            state <= IDLE;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            state <= state_next;
            if (alloc_en) tail <= tail + 1'b1;
            if (pop)      head <= head + 1'b1;
            count <= count + CNT_W'(alloc_en) - CNT_W'(pop);
            if (pop) begin
                lb_wr_data    <= aligned_data;
                lb_wr_rob_tag <= head_entry.rob_tag[ROB_IDX_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_load_buffer.sv
module tb_load_buffer;
    import load_buffer_pkg::*;

    localparam int RW = 4;
    localparam int EW = RW + 32;

    logic          clock = 1'b0;
    logic          reset;
    logic          acu_rd_mem;
    logic [31:0]   acu_addr;
    logic [1:0]    acu_mem_size;
    logic          acu_sign_ext;
    logic [RW-1:0] acu_rob_tag;
    logic          lb_exec_stall;
    logic          Dmem_wait;
    logic [31:0]   Dmem_rdata;
    logic          branch_misprediction;
    logic          lb_wr_written;
    logic          lb_full;
    logic          lb_read_mem;
    logic [31:0]   lb_mem_addr;
    logic          lb_wr_valid;
    logic [31:0]   lb_wr_data;
    logic [RW-1:0] lb_wr_rob_tag;
    lb_state_e     lb_state;
    logic [2:0]    lb_count;

    load_buffer #(.LB_DEPTH(4), .ROB_IDX_W(RW)) dut (
        .clock(clock), .reset(reset),
        .acu_rd_mem(acu_rd_mem), .acu_addr(acu_addr), .acu_mem_size(acu_mem_size),
        .acu_sign_ext(acu_sign_ext), .acu_rob_tag(acu_rob_tag),
        .lb_exec_stall(lb_exec_stall), .Dmem_wait(Dmem_wait), .Dmem_rdata(Dmem_rdata),
        .branch_misprediction(branch_misprediction), .lb_wr_written(lb_wr_written),
        .lb_full(lb_full), .lb_read_mem(lb_read_mem), .lb_mem_addr(lb_mem_addr),
        .lb_wr_valid(lb_wr_valid), .lb_wr_data(lb_wr_data), .lb_wr_rob_tag(lb_wr_rob_tag),
        .lb_state(lb_state), .lb_count(lb_count)
    );

    // clock / reset
    always #5 clock = ~clock;

    int total = 0;
    int bad = 0;
    int wb_cnt = 0;
    logic wb_seen = 1'b0;
    logic [EW-1:0] exp_q[$];

    // memory model
    logic        use_fn = 1'b0;
    logic [31:0] cur_word = 32'h0;
    logic        req_ok = 1'b0;
    logic [31:0] req_addr = 32'h0;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return {~a[15:0], a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        req_ok   = lb_read_mem && !Dmem_wait;
        req_addr = lb_mem_addr;
    end

    always @(posedge clock) begin
        #1 Dmem_rdata = req_ok ? (use_fn ? mem_fn(req_addr) : cur_word) : 32'hDEAD_BEEF;
    end

    // scoreboard: compare each new writeback with the oldest expectation
    always @(negedge clock) begin
        logic [EW-1:0] e;
        if (!reset) begin
            if (lb_wr_valid && !wb_seen) begin
                wb_seen = 1'b1;
                wb_cnt++;
                if (exp_q.size() == 0) begin
                    chk("wb_unexpected", 32'(lb_wr_valid), 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    chk("wb_tag", 32'(lb_wr_rob_tag), 32'(e[EW-1:32]));
                    chk("wb_data", lb_wr_data, e[31:0]);
                end
            end
            if (!lb_wr_valid || lb_wr_written) wb_seen = 1'b0;
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_load(input logic [31:0] a, input logic [1:0] s,
                            input logic se, input logic [RW-1:0] t);
        acu_rd_mem   = 1'b1;
        acu_addr     = a;
        acu_mem_size = s;
        acu_sign_ext = se;
        acu_rob_tag  = t;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || lb_wr_valid) && n < budget) begin
            tick();
            n++;
        end
        chk("drain", 32'(exp_q.size()), 32'h0);
        repeat (2) tick();
    endtask

    typedef struct {
        logic [31:0] word;
        logic [31:0] addr;
        logic [1:0]  size;
        logic        sext;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[12];

    initial begin
        int base;
        logic [31:0] a;
        vecs[0]  = '{32'h80FF_1234, 32'h103, MEM_SIZE_BYTE, 1'b1, 32'hFFFF_FF80};
        vecs[1]  = '{32'h80FF_1234, 32'h103, MEM_SIZE_BYTE, 1'b0, 32'h0000_0080};
        vecs[2]  = '{32'h80FF_1234, 32'h100, MEM_SIZE_BYTE, 1'b1, 32'h0000_0034};
        vecs[3]  = '{32'h80FF_1234, 32'h101, MEM_SIZE_BYTE, 1'b1, 32'h0000_0012};
        vecs[4]  = '{32'h80FF_1234, 32'h102, MEM_SIZE_BYTE, 1'b1, 32'hFFFF_FFFF};
        vecs[5]  = '{32'h80FF_1234, 32'h102, MEM_SIZE_HALF, 1'b1, 32'hFFFF_80FF};
        vecs[6]  = '{32'h80FF_1234, 32'h102, MEM_SIZE_HALF, 1'b0, 32'h0000_80FF};
        vecs[7]  = '{32'h80FF_1234, 32'h100, MEM_SIZE_HALF, 1'b1, 32'h0000_1234};
        vecs[8]  = '{32'h8000_F234, 32'h200, MEM_SIZE_HALF, 1'b1, 32'hFFFF_F234};
        vecs[9]  = '{32'h80FF_1234, 32'h203, MEM_SIZE_HALF, 1'b1, 32'hFFFF_80FF};
        vecs[10] = '{32'h80FF_1234, 32'h202, MEM_SIZE_WORD, 1'b0, 32'h80FF_1234};
        vecs[11] = '{32'h1234_5678, 32'h010, MEM_SIZE_WORD, 1'b1, 32'h1234_5678};

        reset = 1'b1; acu_rd_mem = 1'b0; acu_addr = 32'h0; acu_mem_size = 2'd0;
        acu_sign_ext = 1'b0; acu_rob_tag = '0; lb_exec_stall = 1'b0; Dmem_wait = 1'b0;
        Dmem_rdata = 32'h0; branch_misprediction = 1'b0; lb_wr_written = 1'b1;

        // reset state
        #3;
        chk("rst_full", 32'(lb_full), 32'h0);
        chk("rst_read", 32'(lb_read_mem), 32'h0);
        chk("rst_addr", lb_mem_addr, 32'h0);
        chk("rst_wbv", 32'(lb_wr_valid), 32'h0);
        chk("rst_wbd", lb_wr_data, 32'h0);
        chk("rst_tag", 32'(lb_wr_rob_tag), 32'h0);
        chk("rst_state", 32'(lb_state), 32'(IDLE));
        chk("rst_count", 32'(lb_count), 32'h0);
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        tick();

        // single byte load with writeback held
        lb_wr_written = 1'b0;
        cur_word = 32'h80FF_1234;
        set_load(32'h103, MEM_SIZE_BYTE, 1'b1, 4'd5);
        exp_q.push_back({4'd5, 32'hFFFF_FF80});
        tick();
        acu_rd_mem = 1'b0;
        @(negedge clock);
        chk("lat_req", 32'(lb_read_mem), 32'h1);
        chk("lat_addr", lb_mem_addr, 32'h100);
        @(negedge clock);
        chk("lat_wait_state", 32'(lb_state), 32'(WAIT_DATA));
        chk("lat_wait_noreq", 32'(lb_read_mem), 32'h0);
        @(negedge clock);
        chk("lat_wbv", 32'(lb_wr_valid), 32'h1);
        chk("lat_wbd", lb_wr_data, 32'hFFFF_FF80);
        repeat (3) begin
            @(negedge clock);
            chk("hold_wbv", 32'(lb_wr_valid), 32'h1);
            chk("hold_wbd", lb_wr_data, 32'hFFFF_FF80);
        end
        @(posedge clock);
        #1 lb_wr_written = 1'b1;
        tick();
        @(negedge clock);
        chk("consumed_wbv", 32'(lb_wr_valid), 32'h0);
        chk("consumed_state", 32'(lb_state), 32'(IDLE));
        tick();

        // table of formatting vectors
        for (int i = 0; i < 12; i++) begin
            cur_word = vecs[i].word;
            set_load(vecs[i].addr, vecs[i].size, vecs[i].sext, RW'(i));
            exp_q.push_back({RW'(i), vecs[i].exp});
            tick();
            acu_rd_mem = 1'b0;
            @(negedge clock);
            chk("vec_req", 32'(lb_read_mem), 32'h1);
            chk("vec_addr", lb_mem_addr, vecs[i].addr & 32'hFFFF_FFFC);
            tick();
            drain(20);
        end

        // five allocations under stall: fifth dropped, four in order
        use_fn = 1'b1;
        lb_exec_stall = 1'b1;
        base = wb_cnt;
        for (int k = 0; k < 5; k++) begin
            a = 32'($urandom_range(0, 1023)) << 2;
            set_load(a, MEM_SIZE_WORD, 1'b0, RW'(k + 8));
            if (k < 4) exp_q.push_back({RW'(k + 8), mem_fn(a)});
            tick();
            chk("fill_full", 32'(lb_full), (k >= 3) ? 32'h1 : 32'h0);
            chk("fill_noreq", 32'(lb_read_mem), 32'h0);
        end
        acu_rd_mem = 1'b0;
        chk("fill_count", 32'(lb_count), 32'h4);
        lb_exec_stall = 1'b0;
        drain(80);
        chk("fill_wb_count", 32'(wb_cnt - base), 32'h4);

        // memory busy for three cycles in REQ
        a = 32'h0000_0A56;
        Dmem_wait = 1'b1;
        set_load(a, MEM_SIZE_WORD, 1'b0, 4'd3);
        exp_q.push_back({4'd3, mem_fn(32'h0000_0A54)});
        tick();
        acu_rd_mem = 1'b0;
        repeat (3) begin
            @(negedge clock);
            chk("busy_req", 32'(lb_read_mem), 32'h1);
            chk("busy_state", 32'(lb_state), 32'(REQ));
            chk("busy_addr", lb_mem_addr, 32'h0000_0A54);
            tick();
        end
        Dmem_wait = 1'b0;
        drain(20);

        // writeback withheld with two more loads queued
        lb_wr_written = 1'b0;
        for (int k = 0; k < 3; k++) begin
            a = 32'($urandom_range(0, 1023)) << 2;
            set_load(a, MEM_SIZE_WORD, 1'b1, RW'(k + 1));
            exp_q.push_back({RW'(k + 1), mem_fn(a)});
            tick();
        end
        acu_rd_mem = 1'b0;
        begin
            int n;
            n = 0;
            @(negedge clock);
            while (!lb_wr_valid && n < 10) begin
                @(negedge clock);
                n++;
            end
        end
        chk("held_reach", 32'(lb_wr_valid), 32'h1);
        repeat (5) begin
            chk("held_noreq", 32'(lb_read_mem), 32'h0);
            chk("held_wbv", 32'(lb_wr_valid), 32'h1);
            @(negedge clock);
        end
        @(posedge clock);
        #1 lb_wr_written = 1'b1;
        drain(40);

        // flush in WAIT_DATA with three entries, plus a dropped allocation
        lb_exec_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            set_load(32'h40 + 32'(k * 4), MEM_SIZE_WORD, 1'b0, RW'(k));
            tick();
        end
        acu_rd_mem = 1'b0;
        lb_exec_stall = 1'b0;
        tick();
        chk("flush_pre_state", 32'(lb_state), 32'(WAIT_DATA));
        chk("flush_pre_count", 32'(lb_count), 32'h3);
        branch_misprediction = 1'b1;
        set_load(32'h80, MEM_SIZE_WORD, 1'b0, 4'd9);
        tick();
        branch_misprediction = 1'b0;
        acu_rd_mem = 1'b0;
        @(negedge clock);
        chk("flush_count", 32'(lb_count), 32'h0);
        chk("flush_wbv", 32'(lb_wr_valid), 32'h0);
        chk("flush_state", 32'(lb_state), 32'(IDLE));
        repeat (3) @(negedge clock);
        chk("flush_quiet", 32'(lb_wr_valid), 32'h0);
        tick();

        // asynchronous reset in the middle of REQ
        Dmem_wait = 1'b1;
        set_load(32'h0000_0F0C, MEM_SIZE_WORD, 1'b0, 4'd7);
        tick();
        acu_rd_mem = 1'b0;
        @(negedge clock);
        chk("areset_pre_req", 32'(lb_read_mem), 32'h1);
        #2 reset = 1'b1;
        #1;
        chk("areset_req", 32'(lb_read_mem), 32'h0);
        chk("areset_addr", lb_mem_addr, 32'h0);
        chk("areset_state", 32'(lb_state), 32'(IDLE));
        chk("areset_count", 32'(lb_count), 32'h0);
        chk("areset_wbd", lb_wr_data, 32'h0);
        @(posedge clock);
        #1 reset = 1'b0;
        Dmem_wait = 1'b0;
        repeat (4) @(negedge clock);
        chk("post_reset_state", 32'(lb_state), 32'(IDLE));
        chk("post_reset_wbv", 32'(lb_wr_valid), 32'h0);
        chk("post_reset_q", 32'(exp_q.size()), 32'h0);

        // final report
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/load_buffer.md
LOAD_BUFFER -- requirements
Module: load_buffer

Interface
REQ-001 Parameter LB_DEPTH, default 4: number of load entries; power of two, at least 2.
REQ-002 Parameter ROB_IDX_W, default 4: width of the ROB tag.
REQ-003 `clock` in 1: the single clock; all state updates on its rising edge.
REQ-004 `reset` in 1: reset is asynchronous and active-high.
REQ-005 `acu_rd_mem` in 1: the address-calculation unit presents a load for allocation.
REQ-006 `acu_addr` in 32: load byte address.
REQ-007 `acu_mem_size` in 2: load size (0 = byte, 1 = half, 2 = word).
REQ-008 `acu_sign_ext` in 1: 1 = sign-extend the loaded value, 0 = zero-extend.
REQ-009 `acu_rob_tag` in ROB_IDX_W: ROB tag of the load.
REQ-010 `lb_exec_stall` in 1: from the hazard unit; blocks issue of a new memory request.
REQ-011 `Dmem_wait` in 1: memory busy; a request is not accepted while it is high.
REQ-012 `Dmem_rdata` in 32: read data, valid in the cycle after the request is accepted.
REQ-013 `branch_misprediction` in 1: flush.
REQ-014 `lb_wr_written` in 1: writeback consumed by the CDB/ROB.
REQ-015 `lb_full` out 1: buffer holds LB_DEPTH entries.
REQ-016 `lb_read_mem` out 1: memory read request.
REQ-017 `lb_mem_addr` out 32: request address, word-aligned (bits [1:0] = 0).
REQ-018 `lb_wr_valid` out 1: a writeback is pending.
REQ-019 `lb_wr_data` out 32: extended load result.
REQ-020 `lb_wr_rob_tag` out ROB_IDX_W: ROB tag of the pending writeback.

Function
REQ-021 Circular FIFO with head and tail pointers that wrap modulo LB_DEPTH.
- The count runs 0..LB_DEPTH.
- `lb_full` = (count == LB_DEPTH), decoded from registered state.
REQ-022 Allocation occurs when `acu_rd_mem` is high and `lb_full` is low; the entry is written at the tail and the tail advances.
REQ-023 Allocation while `lb_full` is high is ignored, even if a dequeue happens in the same cycle.
REQ-024 The head controller FSM has states IDLE, REQ, WAIT_DATA and WB.
REQ-025 IDLE: move to REQ when count > 0.
REQ-026 REQ: `lb_read_mem` = ~`lb_exec_stall`; `lb_mem_addr` = {head addr[31:2], 2'b00}.
- Move to WAIT_DATA when `lb_read_mem` is high and `Dmem_wait` is low.
- Otherwise stay in REQ.
REQ-027 WAIT_DATA: capture the formatted `Dmem_rdata` and the head tag into the writeback register, pop the head, and move to WB.
REQ-028 WB: `lb_wr_valid` = 1 and the register holds its value.
- When `lb_wr_written` is high: move to REQ if count > 0, else to IDLE.
REQ-029 `lb_read_mem` is 0 in every state other than REQ, so at most one request is outstanding.
REQ-030 Data formatting uses addr[1:0] as the byte lane.
- Byte: lane = addr[1:0]. Half: lane = addr[1].
- Extend to 32 bits per `acu_sign_ext`.
- Misaligned halves and words use the lane bits truncated; there is no trap.
REQ-031 Load-to-writeback latency with no stalls is 3 cycles: alloc edge, then request accepted, then data captured with `lb_wr_valid` high.
REQ-032 A pop and an allocation in the same cycle leave the count unchanged.
REQ-033 `branch_misprediction` takes priority over all other events at the next edge:
- count, head and tail go to 0;
- the FSM goes to IDLE;
- `lb_wr_valid` goes to 0;
- a response in flight is discarded;
- an allocation in the same cycle is dropped.

Reset
REQ-034 On `reset`, the buffer asynchronously becomes empty:
- count, head and tail = 0;
- FSM = IDLE;
- `lb_full`, `lb_read_mem`, `lb_wr_valid` = 0;
- `lb_wr_data` = 0, `lb_wr_rob_tag` = 0, `lb_mem_addr` = 0.
REQ-035 Reset asserted mid-operation abandons any outstanding request; a `Dmem_rdata` arriving after reset is ignored.

Structure
REQ-036 The shared package holds:
- the LB_STATE enum (IDLE, REQ, WAIT_DATA, WB);
- the MEM_SIZE encodings;
- the LB_ENTRY struct (addr, size, sign_ext, rob_tag).
REQ-037 One sub-module, `load_data_align`: purely combinational lane select and extension, instantiated once on the WAIT_DATA capture path.

Verification
REQ-038 Single load, addr 0x103, byte, sign_ext=1, mem word 0x80FF_1234, no stalls:
- `lb_read_mem` is asserted 1 cycle after alloc with `lb_mem_addr` = 0x100;
- `lb_wr_data` = 0xFFFF_FF80 two cycles after alloc;
- `lb_wr_valid` stays high until `lb_wr_written`.
REQ-039 Allocate 5 loads back-to-back with `lb_exec_stall` high:
- `lb_full` rises after the 4th;
- the 5th is dropped;
- after releasing the stall, exactly 4 writebacks occur in allocation order.
REQ-040 `Dmem_wait` held high for 3 cycles in REQ: `lb_read_mem` stays high, the FSM stays in REQ, and the address is stable.
REQ-041 `lb_wr_written` withheld for 5 cycles with 2 further loads queued: no new request is issued until the writeback is consumed.
REQ-042 `branch_misprediction` in WAIT_DATA with 3 entries: the next cycle shows count 0, `lb_wr_valid` 0 and state IDLE.
REQ-043 `reset` pulsed asynchronously mid-REQ, between clock edges: outputs clear immediately without waiting for a clock edge.
